// File: rtl/jedro_1_irq_ctrl_pkg.sv
// Shared constants for the jedro_1 machine-mode interrupt controller:
// mcause exception codes and FSM state encodings.
package jedro_1_irq_ctrl_pkg;

    // Low five bits of mcause; the interrupt bit is added where the width is known.
    localparam logic [4:0] CSR_MCAUSE_MSI = 5'd3;
    localparam logic [4:0] CSR_MCAUSE_MTI = 5'd7;
    localparam logic [4:0] CSR_MCAUSE_MEI = 5'd11;

    localparam int unsigned IRQ_FSM_WIDTH = 2;

    typedef enum logic [IRQ_FSM_WIDTH-1:0] {
        StIdle    = 2'd0,
        StPending = 2'd1,
        StTaken   = 2'd2,
        StHandler = 2'd3
    } irq_state_e;

endpackage

// File: rtl/jedro_1_sync.sv
// N-stage single-bit synchroniser with synchronous active-high clear.
// STAGES = 0 passes the input straight through for already-synchronous sources.
module jedro_1_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    if (STAGES == 0) begin : g_bypass
        assign q_o = d_i;
    end else begin : g_sync
        logic [STAGES-1:0] ff_q;

        always_ff @(posedge clk_i) begin
            if (clr_i) begin
                ff_q <= '0;
            end else begin
                ff_q[0] <= d_i;
                for (int i = 1; i < int'(STAGES); i++) begin
                    ff_q[i] <= ff_q[i-1];
                end
            end
        end

        assign q_o = ff_q[STAGES-1];
    end

endmodule

// File: rtl/jedro_1_irq_ctrl.sv
// Machine-mode interrupt controller: synchronises and qualifies the three interrupt
// lines, then schedules one trap entry at a clean instruction boundary until MRET.
module jedro_1_irq_ctrl
    import jedro_1_irq_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sw_irq_i,
    input  logic                  timer_irq_i,
    input  logic                  ext_irq_i,
    input  logic                  mstatus_mie_i,
    input  logic                  mie_msie_i,
    input  logic                  mie_mtie_i,
    input  logic                  mie_meie_i,
    input  logic                  instr_boundary_i,
    input  logic                  exc_pending_i,
    input  logic                  mret_i,
    input  logic [DATA_WIDTH-1:0] curr_pc_i,
    output logic [2:0]            irq_pending_o,
    output logic                  irq_req_o,
    output logic                  irq_take_o,
    output logic [DATA_WIDTH-1:0] irq_cause_o,
    output logic [DATA_WIDTH-1:0] irq_epc_o
);

    logic msip, mtip, meip;
    logic [2:0] qual;
    logic       any_qual;
    logic [DATA_WIDTH-1:0] sel_cause;

    irq_state_e state_q;
    logic req_q, take_q;
    logic [DATA_WIDTH-1:0] cause_q, epc_q;

    jedro_1_sync #(.STAGES(SYNC_STAGES)) u_sync_msi (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .d_i   (sw_irq_i),
        .q_o   (msip)
    );

    jedro_1_sync #(.STAGES(SYNC_STAGES)) u_sync_mti (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .d_i   (timer_irq_i),
        .q_o   (mtip)
    );

    jedro_1_sync #(.STAGES(SYNC_STAGES)) u_sync_mei (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .d_i   (ext_irq_i),
        .q_o   (meip)
    );

    assign irq_pending_o = {meip, mtip, msip};
    assign qual          = irq_pending_o & {mie_meie_i, mie_mtie_i, mie_msie_i}
                           & {3{mstatus_mie_i}};
    assign any_qual      = |qual;

    // Priority MEI > MSI > MTI; only consumed when any_qual is set.
    always_comb begin
        sel_cause                 = '0;
        sel_cause[DATA_WIDTH-1]   = 1'b1;
        if (qual[2]) begin
            sel_cause[4:0] = CSR_MCAUSE_MEI;
        end else if (qual[0]) begin
            sel_cause[4:0] = CSR_MCAUSE_MSI;
        end else begin
            sel_cause[4:0] = CSR_MCAUSE_MTI;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            take_q  <= 1'b0;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            take_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (any_qual) begin
                        state_q <= StPending;
                        req_q   <= 1'b1;
                    end
                end
                StPending: begin
                    if (!any_qual) begin
                        state_q <= StIdle;
                        req_q   <= 1'b0;
                    end else if (instr_boundary_i && !exc_pending_i) begin
                        state_q <= StTaken;
                        req_q   <= 1'b0;
                        take_q  <= 1'b1;
                        cause_q <= sel_cause;
                        epc_q   <= curr_pc_i;
                    end
                end
                // mret_i here is illegal and deliberately ignored.
                StTaken:   state_q <= StHandler;
                StHandler: begin
                    if (mret_i) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign irq_req_o   = req_q;
    assign irq_take_o  = take_q;
    assign irq_cause_o = cause_q;
    assign irq_epc_o   = epc_q;

endmodule

// File: tb/tb_jedro_1_irq_ctrl.sv
// Directed self-checking bench for jedro_1_irq_ctrl with two synchroniser stages.
module tb_jedro_1_irq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        sw_irq_i = 1'b0, timer_irq_i = 1'b0, ext_irq_i = 1'b0;
    logic        mstatus_mie_i = 1'b0;
    logic        mie_msie_i = 1'b0, mie_mtie_i = 1'b0, mie_meie_i = 1'b0;
    logic        instr_boundary_i = 1'b0, exc_pending_i = 1'b0, mret_i = 1'b0;
    logic [31:0] curr_pc_i = 32'h0;
    logic [2:0]  irq_pending_o;
    logic        irq_req_o, irq_take_o;
    logic [31:0] irq_cause_o, irq_epc_o;

    int n_checks = 0;
    int n_fail   = 0;
    int takes;

    always #5 clk_i = ~clk_i;

    jedro_1_irq_ctrl #(
        .DATA_WIDTH  (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .sw_irq_i         (sw_irq_i),
        .timer_irq_i      (timer_irq_i),
        .ext_irq_i        (ext_irq_i),
        .mstatus_mie_i    (mstatus_mie_i),
        .mie_msie_i       (mie_msie_i),
        .mie_mtie_i       (mie_mtie_i),
        .mie_meie_i       (mie_meie_i),
        .instr_boundary_i (instr_boundary_i),
        .exc_pending_i    (exc_pending_i),
        .mret_i           (mret_i),
        .curr_pc_i        (curr_pc_i),
        .irq_pending_o    (irq_pending_o),
        .irq_req_o        (irq_req_o),
        .irq_take_o       (irq_take_o),
        .irq_cause_o      (irq_cause_o),
        .irq_epc_o        (irq_epc_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic count_takes(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (irq_take_o) cnt++;
        end
    endtask

    // Drop all lines, let the synchronisers drain, then return from the handler.
    task automatic leave_handler();
        sw_irq_i = 1'b0; timer_irq_i = 1'b0; ext_irq_i = 1'b0;
        repeat (3) tick();
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        tick();
    endtask

    initial begin
        // Reset
        rst_i = 1'b1;
        tick();
        tick();
        check("rst_req",     {31'b0, irq_req_o},  32'd0);
        check("rst_take",    {31'b0, irq_take_o}, 32'd0);
        check("rst_cause",   irq_cause_o,         32'd0);
        check("rst_epc",     irq_epc_o,           32'd0);
        check("rst_pending", {29'b0, irq_pending_o}, 32'd0);
        rst_i = 1'b0;

        // Basic entry: line sampled at E1, take after E4
        mstatus_mie_i = 1'b1; mie_meie_i = 1'b1;
        instr_boundary_i = 1'b1; curr_pc_i = 32'h0000_0100;
        ext_irq_i = 1'b1;
        tick();
        check("basic_pend_e1", {29'b0, irq_pending_o}, 32'd0);
        tick();
        check("basic_pend_e2", {29'b0, irq_pending_o}, 32'd4);
        check("basic_req_e2",  {31'b0, irq_req_o},     32'd0);
        tick();
        check("basic_req_e3",  {31'b0, irq_req_o},     32'd1);
        check("basic_take_e3", {31'b0, irq_take_o},    32'd0);
        tick();
        check("basic_take_e4", {31'b0, irq_take_o},    32'd1);
        check("basic_cause",   irq_cause_o,            32'h8000_000B);
        check("basic_epc",     irq_epc_o,              32'h0000_0100);
        check("basic_req_e4",  {31'b0, irq_req_o},     32'd0);
        count_takes(4, takes);
        check("basic_single_take", takes, 32'd0);
        leave_handler();

        // Priority: all enabled -> MEI
        mie_msie_i = 1'b1; mie_mtie_i = 1'b1; mie_meie_i = 1'b1;
        curr_pc_i = 32'h0000_0200;
        sw_irq_i = 1'b1; timer_irq_i = 1'b1; ext_irq_i = 1'b1;
        repeat (4) tick();
        check("prio_all_take",  {31'b0, irq_take_o}, 32'd1);
        check("prio_all_cause", irq_cause_o,         32'h8000_000B);
        check("prio_all_epc",   irq_epc_o,           32'h0000_0200);
        leave_handler();

        // Priority: MEIE cleared -> MSI beats MTI
        mie_meie_i = 1'b0;
        sw_irq_i = 1'b1; timer_irq_i = 1'b1; ext_irq_i = 1'b1;
        repeat (4) tick();
        check("prio_nomei_take",  {31'b0, irq_take_o}, 32'd1);
        check("prio_nomei_cause", irq_cause_o,         32'h8000_0003);
        leave_handler();

        // Exception collision
        mie_msie_i = 1'b0; mie_mtie_i = 1'b0; mie_meie_i = 1'b1;
        instr_boundary_i = 1'b0; curr_pc_i = 32'h0000_0300;
        ext_irq_i = 1'b1;
        repeat (3) tick();
        check("exc_req_pending", {31'b0, irq_req_o}, 32'd1);
        exc_pending_i = 1'b1; instr_boundary_i = 1'b1;
        count_takes(3, takes);
        check("exc_no_take", takes, 32'd0);
        check("exc_req_held", {31'b0, irq_req_o}, 32'd1);
        exc_pending_i = 1'b0;
        tick();
        check("exc_take_after", {31'b0, irq_take_o}, 32'd1);
        check("exc_epc",        irq_epc_o,           32'h0000_0300);
        leave_handler();

        // Withdrawal: timer enable cleared while pending
        mie_meie_i = 1'b0; mie_mtie_i = 1'b1;
        instr_boundary_i = 1'b0;
        timer_irq_i = 1'b1;
        repeat (3) tick();
        check("wd_req_pending", {31'b0, irq_req_o}, 32'd1);
        mie_mtie_i = 1'b0;
        tick();
        check("wd_req_idle", {31'b0, irq_req_o}, 32'd0);
        instr_boundary_i = 1'b1;
        count_takes(6, takes);
        check("wd_no_take", takes, 32'd0);
        check("wd_req_stays", {31'b0, irq_req_o}, 32'd0);
        timer_irq_i = 1'b0;
        repeat (3) tick();

        // No nesting, then MRET re-request
        mie_msie_i = 1'b1;
        sw_irq_i = 1'b1;
        repeat (4) tick();
        check("nest_first_take",  {31'b0, irq_take_o}, 32'd1);
        check("nest_first_cause", irq_cause_o,         32'h8000_0003);
        takes = 0;
        for (int i = 0; i < 6; i++) begin
            sw_irq_i = ~sw_irq_i;
            tick();
            if (irq_take_o) takes++;
        end
        sw_irq_i = 1'b1;
        repeat (3) begin
            tick();
            if (irq_take_o) takes++;
        end
        check("nest_no_take", takes, 32'd0);
        check("nest_no_req",  {31'b0, irq_req_o}, 32'd0);
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        check("mret_take_m0", {31'b0, irq_take_o}, 32'd0);
        tick();
        check("mret_req_m1",  {31'b0, irq_req_o},  32'd1);
        check("mret_take_m1", {31'b0, irq_take_o}, 32'd0);
        tick();
        check("mret_take_m2", {31'b0, irq_take_o}, 32'd1);
        check("mret_cause",   irq_cause_o,         32'h8000_0003);
        leave_handler();

        // Reset mid-PENDING
        mie_msie_i = 1'b0; mie_meie_i = 1'b1;
        instr_boundary_i = 1'b0;
        ext_irq_i = 1'b1;
        repeat (3) tick();
        check("rstmid_req_before", {31'b0, irq_req_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rstmid_req",     {31'b0, irq_req_o},     32'd0);
        check("rstmid_take",    {31'b0, irq_take_o},    32'd0);
        check("rstmid_cause",   irq_cause_o,            32'd0);
        check("rstmid_epc",     irq_epc_o,              32'd0);
        check("rstmid_pending", {29'b0, irq_pending_o}, 32'd0);
        tick();
        check("rstmid_req_e1",  {31'b0, irq_req_o},     32'd0);
        tick();
        check("rstmid_pend_e2", {29'b0, irq_pending_o}, 32'd4);
        check("rstmid_req_e2",  {31'b0, irq_req_o},     32'd0);
        tick();
        check("rstmid_req_e3",  {31'b0, irq_req_o},     32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
